signed_accum_seq: RTL and testbench
===================================

SIGNED_ACCUM_SEQ -- requirements
Module: signed_accum_seq

Interface
REQ-001 The block SHALL have parameter DW, default 8, the signed operand width in bits.
REQ-002 The block SHALL have parameter LEN, default 4, the number of operands summed per job (LEN >= 2).
REQ-003 The block SHALL have parameter AW, default DW+$clog2(LEN), the signed result width in bits.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  a one-cycle job request, sampled only in IDLE.
REQ-007 The block SHALL have port in_valid  input  1  in_data holds a valid operand.
REQ-008 The block SHALL have port in_data  input  DW  a two's-complement operand.
REQ-009 The block SHALL have port in_ready  output  1  the block accepts an operand this cycle.
REQ-010 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 The block SHALL have port out_valid  output  1  out_data holds the finished sum.
REQ-012 The block SHALL have port out_data  output  AW  the two's-complement sum of the job's LEN operands.
REQ-013 The block SHALL have port out_ready  input  1  the consumer accepts out_data this cycle.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ACCUM and DONE.
REQ-015 In IDLE, start=1 SHALL clear the accumulator and the operand counter and move the FSM to ACCUM on the next edge; start=0 SHALL keep the FSM in IDLE.
REQ-016 start SHALL be ignored in ACCUM and DONE, with no effect on state, count or accumulator.
REQ-017 in_ready SHALL equal 1 in ACCUM and 0 in IDLE and DONE (Moore output, independent of in_valid).
REQ-018 An operand transfer SHALL occur exactly on cycles where in_valid=1 and in_ready=1; in_valid=1 outside ACCUM SHALL be ignored.
REQ-019 On each transfer, the accumulator SHALL update to acc + sign-extend(in_data, AW) through one shared signed adder, and the counter SHALL increment by 1.
REQ-020 Cycles in ACCUM with in_valid=0 SHALL hold the accumulator and counter unchanged, for any number of cycles.
REQ-021 The transfer with counter = LEN-1 SHALL be the final one: the FSM SHALL enter DONE on that edge, and out_valid SHALL be 1 in the following cycle.
REQ-022 Latency from the final transfer to out_valid SHALL be exactly one cycle.
REQ-023 out_data SHALL equal the accumulator register; in DONE it SHALL hold stable until the handshake completes.
REQ-024 In DONE, out_valid SHALL be 1; out_valid=1 with out_ready=1 SHALL complete the job and return the FSM to IDLE on that edge.
REQ-025 In DONE with out_ready=0, state, out_valid and out_data SHALL hold indefinitely.
REQ-026 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-027 Arithmetic SHALL be two's complement with AW bits; AW >= DW+ceil(log2 LEN) ensures no overflow, so no saturation or wrap handling is required.
REQ-028 A new start SHALL be accepted no earlier than the cycle after DONE exits; there is no back-to-back overlap.

Reset
REQ-029 rst=0 SHALL, asynchronously and in any state including mid-job, force: state=IDLE, accumulator=0, counter=0, in_ready=0, busy=0, out_valid=0, out_data=0.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until the first start; partial job data SHALL be discarded.

Verification (DW=8, LEN=4, AW=10)
REQ-031 start, then operands 10, 20, 30, 40 on consecutive cycles -> one cycle later out_valid=1 and out_data=100 (10'h064).
REQ-032 Operands -128 x4 -> out_data=-512 (10'h200); operands 127, -128, 1, -1 -> out_data=-1 (10'h3FF).
REQ-033 Operands with in_valid gaps of 0, 3 and 1 cycles, and out_ready held low 5 cycles -> correct sum; out_valid and out_data stay stable through the stall; IDLE follows the out_ready=1 edge.
REQ-034 start pulsed during ACCUM and during DONE, and in_valid=1 while in IDLE -> no effect on the result or state.
REQ-035 rst=0 applied after 2 accepted operands -> all outputs 0 immediately; after release, a new start with operands 1, 2, 3, 4 -> out_data=10.

Source files
------------

// File: rtl/signed_accum_seq.sv
// signed_accum_seq: sums LEN two's-complement operands per job through one
// shared adder, then presents the AW-bit sum with a valid/ready handshake.
module signed_accum_seq #(
  parameter int DW  = 8,
  parameter int LEN = 4,
  parameter int AW  = DW + $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  input  logic          out_ready
);

  // Counter only needs to reach LEN-1.
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] r_acc;

  logic                 w_clear;
  logic                 w_xfer;
  logic                 w_last;
  logic signed [AW-1:0] w_operand;
  logic signed [AW-1:0] w_sum;

  // Sign-extend the operand to the result width and feed the single adder.
  assign w_operand = {{(AW-DW){in_data[DW-1]}}, in_data};
  assign w_sum     = r_acc + w_operand;
  assign w_xfer    = in_valid & in_ready;
  assign w_last    = (r_cnt == LAST_IDX);
  assign out_data  = r_acc;

  // State register; reset drops any job in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and Moore handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        // in_ready is constant here, so the transfer test is just in_valid.
        if (in_valid && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Accumulator and operand counter: cleared by an accepted start,
  // advanced only on an operand transfer, otherwise held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_signed_accum_seq.sv
// Directed plus randomized bench for signed_accum_seq (DW=8, LEN=4, AW=10).
module tb_signed_accum_seq;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int ops  [LEN];
  int gaps [LEN];

  always #5 clk = ~clk;

  signed_accum_seq #(.DW(DW), .LEN(LEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer sum of the job's operands, reduced to AW bits.
  function automatic logic [AW-1:0] ref_sum();
    int s = 0;
    for (int i = 0; i < LEN; i++) s += ops[i];
    return AW'(s);
  endfunction

  // One job: inputs change and outputs are sampled on the falling edge.
  task automatic run_job(input string name, input int stall, input bit poke);
    logic [AW-1:0] exp;
    exp = ref_sum();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ":accum_busy"}, 32'(busy), 32'd1);
    chk({name, ":accum_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < LEN; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = poke;
        @(negedge clk);
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = 8'(ops[i]);
      start    = poke;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      if (i < LEN - 1) chk({name, ":no_early_valid"}, 32'(out_valid), 32'd0);
    end
    // One cycle after the final transfer the sum must be presented.
    chk({name, ":done_valid"}, 32'(out_valid), 32'd1);
    chk({name, ":done_ready_low"}, 32'(in_ready), 32'd0);
    chk({name, ":sum"}, 32'(out_data), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      start    = poke;
      in_valid = poke;
      in_data  = 8'($urandom);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      chk({name, ":stall_valid"}, 32'(out_valid), 32'd1);
      chk({name, ":stall_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ":idle_busy"}, 32'(busy), 32'd0);
    chk({name, ":idle_valid"}, 32'(out_valid), 32'd0);
    $display("job %s: sum=0x%0h expected=0x%0h stall=%0d", name, out_data, exp, stall);
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // in_valid while idle is ignored.
    in_valid = 1'b1;
    in_data  = 8'd55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_data", 32'(out_data), 32'd0);

    // Directed jobs.
    ops  = '{10, 20, 30, 40};
    gaps = '{0, 0, 0, 0};
    run_job("basic", 0, 1'b0);
    ops  = '{-128, -128, -128, -128};
    run_job("minneg", 0, 1'b0);
    ops  = '{127, -128, 1, -1};
    run_job("mixed", 0, 1'b0);
    ops  = '{5, -17, 99, -3};
    gaps = '{0, 3, 1, 0};
    run_job("gaps_stall", 5, 1'b0);
    ops  = '{-60, 33, 71, -2};
    gaps = '{1, 2, 0, 1};
    run_job("poke", 3, 1'b1);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < LEN; i++) begin
        ops[i]  = int'($signed(8'($urandom)));
        gaps[i] = int'($urandom_range(0, 3));
      end
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 4)), 1'($urandom));
    end

    // Reset in the middle of a job.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd50;
    @(negedge clk);
    in_data  = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_busy", 32'(busy), 32'd0);
    ops  = '{1, 2, 3, 4};
    gaps = '{0, 0, 0, 0};
    run_job("after_rst", 1, 1'b0);
    chk("after_rst_sum", 32'(out_data), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
